// File: rtl/microwave_ctrl_timed.sv
// microwave_ctrl_timed: microwave oven controller with cook timer, tick prescaler, power duty cycle and bell
// All outputs decode from registered state/counters only, so there is no input-to-output path.
module microwave_ctrl_timed #(
    parameter int TIME_W      = 8,
    parameter int TICK_DIV    = 4,
    parameter int PWR_W       = 2,
    parameter int BELL_CYCLES = 3
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              door,
    input  logic              start,
    input  logic              cancel,
    input  logic              time_load,
    input  logic [TIME_W-1:0] time_in,
    input  logic [PWR_W-1:0]  power,
    output logic              heat,
    output logic              light,
    output logic              bell,
    output logic              busy,
    output logic [TIME_W-1:0] remaining
);
    localparam int PS_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int BW   = BELL_CYCLES > 1 ? $clog2(BELL_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, COOK, PAUSE, OPEN, DONE} state_t;

    state_t           state, state_n;
    logic [PWR_W-1:0] power_r, pwm_cnt;
    logic [PS_W-1:0]  presc;
    logic [BW-1:0]    bell_cnt;
    logic             wrap, last;

    assign wrap = presc == PS_W'(TICK_DIV - 1);
    assign last = bell_cnt == BW'(BELL_CYCLES - 1);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            remaining <= '0;
            power_r   <= '0;
            presc     <= '0;
            pwm_cnt   <= '0;
            bell_cnt  <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE, OPEN: begin
                    presc   <= '0;
                    pwm_cnt <= '0;
                    if (cancel) remaining <= '0;
                    else if (time_load) begin
                        remaining <= time_in;
                        power_r   <= power;
                    end
                end
                COOK: begin
                    bell_cnt <= '0;
                    if (cancel) remaining <= '0;
                    else if (!door) begin
                        presc     <= wrap ? '0 : presc + PS_W'(1);
                        pwm_cnt   <= pwm_cnt + PWR_W'(1);
                        remaining <= wrap ? remaining - TIME_W'(1) : remaining;
                    end
                end
                PAUSE: if (cancel) remaining <= '0;
                DONE: bell_cnt <= bell_cnt + BW'(1);
                default: ;
            endcase
        end
    end

    // Priority everywhere: cancel, then door, then start/tick.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  state_n = cancel ? IDLE : door ? OPEN :
                             (start && !time_load && remaining != '0) ? COOK : IDLE;
            OPEN:  state_n = (cancel || door) ? OPEN : IDLE;
            COOK:  state_n = cancel ? IDLE : door ? PAUSE :
                             (wrap && remaining == TIME_W'(1)) ? DONE : COOK;
            PAUSE: state_n = cancel ? (door ? OPEN : IDLE) : (!door && start) ? COOK : PAUSE;
            DONE:  state_n = cancel ? IDLE : door ? OPEN : last ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        heat  = state == COOK && pwm_cnt <= power_r;
        light = state == COOK || state == PAUSE || state == OPEN;
        bell  = state == DONE;
        busy  = state == COOK || state == PAUSE;
    end
endmodule

// File: tb/tb_microwave_ctrl_timed.sv
// tb_microwave_ctrl_timed: directed self-checking bench for microwave_ctrl_timed with default parameters
// Inputs change 1ns after each rising edge; outputs are checked in that same window.
module tb_microwave_ctrl_timed;
    logic       clk = 0, nrst = 0;
    logic       door = 0, start = 0, cancel = 0, time_load = 0;
    logic [7:0] time_in = 0;
    logic [1:0] power = 0;
    logic       heat, light, bell, busy;
    logic [7:0] remaining;
    int         checks = 0, failures = 0;

    microwave_ctrl_timed dut (
        .clk(clk), .nrst(nrst), .door(door), .start(start), .cancel(cancel),
        .time_load(time_load), .time_in(time_in), .power(power),
        .heat(heat), .light(light), .bell(bell), .busy(busy), .remaining(remaining)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] t, input logic [1:0] p);
        time_load = 1; time_in = t; power = p;
        tick();
        time_load = 0;
    endtask

    task automatic go();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((light || bell) && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {heat, light, bell, busy}, 4'b0000);
    endtask

    initial begin
        int n;
        #2;
        chk("reset_outs", {heat, light, bell, busy}, 4'b0000);
        chk("reset_rem", remaining, 0);
        #10 nrst = 1;
        tick();

        // 1: T=3 full power, 12 heat cycles then 3 bell cycles
        load(3, 3);
        chk("t1_loaded", remaining, 3);
        chk("t1_idle", {heat, light, bell, busy}, 4'b0000);
        go();
        n = heat;
        for (int k = 1; k < 12; k++) begin
            tick();
            n += heat;
            chk("t1_rem", remaining, 3 - k / 4);
            chk("t1_cook", {light, busy, bell}, 3'b110);
        end
        chk("t1_heat_cycles", n, 12);
        for (int k = 12; k < 15; k++) begin
            tick();
            chk("t1_bell", {heat, light, bell, busy}, 4'b0010);
            chk("t1_rem0", remaining, 0);
        end
        tick();
        chk("t1_back_idle", {heat, light, bell, busy}, 4'b0000);

        // 2: power 1 gives 1,1,0,0 pattern
        load(2, 1);
        go();
        for (int k = 0; k < 8; k++) begin
            chk("t2_heat", heat, (k % 4) <= 1);
            chk("t2_light", light, 1);
            if (k < 7) tick();
        end
        tick();
        chk("t2_done", bell, 1);
        wait_idle("t2_idle");

        // 3: pause, closed door without start holds, resume takes 14 cycles
        load(5, 3);
        go();
        repeat (6) tick();
        door = 1;
        tick();
        chk("t3_pause", {heat, light, bell, busy}, 4'b0101);
        chk("t3_rem", remaining, 4);
        door = 0;
        repeat (10) tick();
        chk("t3_hold", {heat, light, bell, busy}, 4'b0101);
        chk("t3_hold_rem", remaining, 4);
        go();
        n = 0;
        for (int k = 0; k < 40 && !bell; k++) begin
            n += heat;
            tick();
        end
        chk("t3_resume_cycles", n, 14);
        chk("t3_done", bell, 1);
        wait_idle("t3_idle");

        // 4: cancel mid-cook, then start with nothing loaded
        load(4, 3);
        go();
        repeat (4) tick();
        chk("t4_rem3", remaining, 3);
        cancel = 1;
        tick();
        cancel = 0;
        chk("t4_cancel", {heat, light, bell, busy}, 4'b0000);
        chk("t4_cancel_rem", remaining, 0);
        go();
        chk("t4_start_empty", {heat, light, bell, busy}, 4'b0000);

        // 5: door in DONE, door+start in IDLE, load during COOK, load+start together
        load(1, 0);
        go();
        repeat (4) tick();
        chk("t5_bell1", bell, 1);
        tick();
        chk("t5_bell2", bell, 1);
        door = 1;
        tick();
        chk("t5_open", {heat, light, bell, busy}, 4'b0100);
        door = 0;
        tick();
        chk("t5_closed", {heat, light, bell, busy}, 4'b0000);
        load(2, 3);
        door = 1; start = 1;
        tick();
        chk("t5_door_start", {heat, light, bell, busy}, 4'b0100);
        door = 0; start = 0;
        tick();
        go();
        chk("t5_cook", busy, 1);
        time_load = 1; time_in = 9;
        tick();
        time_load = 0;
        chk("t5_load_ignored", remaining, 2);
        cancel = 1;
        tick();
        cancel = 0;
        time_load = 1; time_in = 6; start = 1;
        tick();
        time_load = 0; start = 0;
        chk("t5_load_start_rem", remaining, 6);
        chk("t5_load_start_idle", busy, 0);

        // 6: asynchronous reset mid-cook and mid-done
        go();
        repeat (2) tick();
        chk("t6_cooking", heat, 1);
        #2 nrst = 0;
        #1 chk("t6_rst_cook", {heat, light, bell, busy}, 4'b0000);
        chk("t6_rst_rem", remaining, 0);
        #1 nrst = 1;
        tick();
        chk("t6_after_rel", {heat, light, bell, busy, remaining}, 12'h000);
        load(1, 2);
        go();
        repeat (4) tick();
        chk("t6_in_done", bell, 1);
        #2 nrst = 0;
        #1 chk("t6_rst_done", {heat, light, bell, busy}, 4'b0000);
        #1 nrst = 1;
        tick();
        chk("t6_after_rel2", {heat, light, bell, busy, remaining}, 12'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
